half_subtractor_b: RTL and testbench

HALF_SUBTRACTOR_B -- requirements
Module: half_subtractor_b

---
 rtl/half_subtractor_b.sv | 75 +++++++
 tb/tb_half_subtractor_b.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/half_subtractor_b.sv
// ----------------------------------------------------------------------------
// half_subtractor_b
//
// Purpose:
//   Registered unsigned subtractor. It samples a and b on each rising clk edge
//   and presents (a - b) mod 2^WIDTH on d and the borrow-out (a < b) on borrow
//   one clock later. No combinational path runs from a/b to d/borrow.
//
// Parameters:
//   WIDTH   operand and difference width in bits (1..32)
//
// Ports:
//   clk     input            sole clock, rising-edge active
//   rst     input            synchronous active-high reset; clears d and borrow
//   a       input  [WIDTH]   minuend, unsigned
//   b       input  [WIDTH]   subtrahend, unsigned
//   d       output [WIDTH]   registered difference
//   borrow  output           registered borrow-out
// ----------------------------------------------------------------------------
module half_subtractor_b #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] d,
    output logic             borrow
);

    // Ripple-borrow chain. brw_chain[i] is the borrow flowing into bit i;
    // bit 0 has no borrow-in, so the LSB cell acts as a plain half subtractor
    // and the upper cells as full subtractors.
    logic [WIDTH:0]   brw_chain;
    logic [WIDTH-1:0] diff_next;

    assign brw_chain[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign diff_next[gi]   = a[gi] ^ b[gi] ^ brw_chain[gi];
            // A borrow leaves this bit when b exceeds a here, or when the
            // two bits are equal and a borrow is already arriving.
            assign brw_chain[gi+1] = (~a[gi] & b[gi])
                                   | (~(a[gi] ^ b[gi]) & brw_chain[gi]);
        end
    endgenerate

    // Output registers and their next-state values.
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] d_d;
    logic             borrow_q;
    logic             borrow_d;

    always_comb begin
        d_d      = diff_next;
        borrow_d = brw_chain[WIDTH];
    end

    // Reset takes priority over the data update, so a pending result from
    // the edge before reset is simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q      <= '0;
            borrow_q <= 1'b0;
        end else begin
            d_q      <= d_d;
            borrow_q <= borrow_d;
        end
    end

    assign d      = d_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_half_subtractor_b.sv
// ----------------------------------------------------------------------------
// tb_half_subtractor_b
//
// Self-checking bench for half_subtractor_b. Three instances (WIDTH = 1, 4, 8)
// share clock and reset. Inputs change on the falling edge; outputs are
// sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_half_subtractor_b;

    logic       clk;
    logic       rst;
    logic       a1, b1, d1, bo1;
    logic [3:0] a4, b4, d4;
    logic       bo4;
    logic [7:0] a8, b8, d8;
    logic       bo8;

    int vectors;
    int miscompares;

    half_subtractor_b #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .d(d1), .borrow(bo1)
    );
    half_subtractor_b #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .d(d4), .borrow(bo4)
    );
    half_subtractor_b #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .d(d8), .borrow(bo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Move to the next rising edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1;
        a4 = 4'h1; b4 = 4'h1;
        a8 = 8'h01; b8 = 8'h01;
        for (int e = 0; e < 2; e++) begin
            step();
            vectors++;
            if (d1 !== 1'b0 || bo1 !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_w1 edge %0d: got d=%b borrow=%b, want d=0 borrow=0", e, d1, bo1);
            end
            vectors++;
            if (d4 !== 4'h0 || bo4 !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_w4 edge %0d: got d=%h borrow=%b, want d=0 borrow=0", e, d4, bo4);
            end
            vectors++;
            if (d8 !== 8'h00 || bo8 !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_w8 edge %0d: got d=%h borrow=%b, want d=0 borrow=0", e, d8, bo8);
            end
            $display("reset edge %0d: d1=%b bo1=%b d4=%h bo4=%b d8=%h bo8=%b", e, d1, bo1, d4, bo4, d8, bo8);
        end
    endtask

    task automatic test_truth_table();
        logic [3:0] ta, tb, td, tbo;
        ta  = 4'b1100; // bit i = a of vector i, order (0,0),(0,1),(1,0),(1,1)
        tb  = 4'b1010;
        td  = 4'b0110;
        tbo = 4'b0010;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a1 = ta[3-i];
            b1 = tb[3-i];
            step();
            vectors++;
            if (d1 !== td[3-i] || bo1 !== tbo[3-i]) begin
                miscompares++;
                $display("FAIL truth_w1 a=%b b=%b: got d=%b borrow=%b, want d=%b borrow=%b",
                         a1, b1, d1, bo1, td[3-i], tbo[3-i]);
            end
            $display("truth a=%b b=%b -> d=%b borrow=%b", a1, b1, d1, bo1);
            @(negedge clk);
        end
    endtask

    task automatic test_hold();
        // Register 0x0 - 0xF on width 4, then wiggle inputs mid-cycle.
        a4 = 4'h0; b4 = 4'hF;
        step();
        vectors++;
        if (d4 !== 4'h1 || bo4 !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_setup: got d=%h borrow=%b, want d=1 borrow=1", d4, bo4);
        end
        @(negedge clk);
        a4 = 4'hA; b4 = 4'h3;
        #2;
        a4 = 4'h5; b4 = 4'h9;
        #1;
        vectors++;
        if (d4 !== 4'h1 || bo4 !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_between_edges: got d=%h borrow=%b, want d=1 borrow=1", d4, bo4);
        end
        $display("hold mid-cycle d=%h borrow=%b", d4, bo4);
        a4 = 4'hA; b4 = 4'h3;
        step();
        vectors++;
        if (d4 !== 4'h7 || bo4 !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_next_edge: got d=%h borrow=%b, want d=7 borrow=0", d4, bo4);
        end
        $display("hold next edge a=%h b=%h -> d=%h borrow=%b", a4, b4, d4, bo4);
    endtask

    task automatic test_width4();
        logic [3:0] va [4];
        logic [3:0] vb [4];
        logic [3:0] vd [4];
        logic       vbo [4];
        va = '{4'h0, 4'hA, 4'h6, 4'hF};
        vb = '{4'hF, 4'h3, 4'h6, 4'h0};
        vd = '{4'h1, 4'h7, 4'h0, 4'hF};
        vbo = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a4 = va[i];
            b4 = vb[i];
            step();
            vectors++;
            if (d4 !== vd[i] || bo4 !== vbo[i]) begin
                miscompares++;
                $display("FAIL w4 a=%h b=%h: got d=%h borrow=%b, want d=%h borrow=%b",
                         a4, b4, d4, bo4, vd[i], vbo[i]);
            end
            $display("w4 a=%h b=%h -> d=%h borrow=%b", a4, b4, d4, bo4);
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b1;
        step();
        vectors++;
        if (d1 !== 1'b1 || bo1 !== 1'b1) begin
            miscompares++;
            $display("FAIL rstprio_pre: got d=%b borrow=%b, want d=1 borrow=1", d1, bo1);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        vectors++;
        if (d1 !== 1'b0 || bo1 !== 1'b0) begin
            miscompares++;
            $display("FAIL rstprio_reset_wins: got d=%b borrow=%b, want d=0 borrow=0", d1, bo1);
        end
        $display("rstprio reset edge a=%b b=%b -> d=%b borrow=%b", a1, b1, d1, bo1);
        @(negedge clk);
        rst = 1'b0;
        step();
        vectors++;
        if (d1 !== 1'b1 || bo1 !== 1'b1) begin
            miscompares++;
            $display("FAIL rstprio_first_after: got d=%b borrow=%b, want d=1 borrow=1", d1, bo1);
        end
        $display("rstprio first edge after reset a=%b b=%b -> d=%b borrow=%b", a1, b1, d1, bo1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d;
        logic       exp_bo;
        for (int i = 0; i < 1002; i++) begin
            @(negedge clk);
            if (i == 0) begin
                a8 = 8'h00; b8 = 8'hFF;
            end else if (i == 1) begin
                a8 = 8'h80; b8 = 8'h80;
            end else begin
                a8 = 8'($urandom_range(0, 255));
                b8 = 8'($urandom_range(0, 255));
            end
            exp_d  = a8 - b8;
            exp_bo = (a8 < b8);
            step();
            vectors++;
            if (d8 !== exp_d || bo8 !== exp_bo) begin
                miscompares++;
                $display("FAIL w8_seq %0d a=%h b=%h: got d=%h borrow=%b, want d=%h borrow=%b",
                         i, a8, b8, d8, bo8, exp_d, exp_bo);
            end
            $display("w8 %0d a=%h b=%h -> d=%h borrow=%b", i, a8, b8, d8, bo8);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        a1 = 1'b0; b1 = 1'b0;
        a4 = 4'h0; b4 = 4'h0;
        a8 = 8'h00; b8 = 8'h00;
        test_reset();
        test_truth_table();
        test_hold();
        test_width4();
        test_reset_priority();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
